// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the MULT sequencer: FSM encoding, HI/LO select
// values and default timing parameters.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_RUN     = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  localparam int TIMEOUT_DEF = 64;
  localparam int RECOVER_DEF = 1;
  localparam int CNT_W_DEF   = 7;

endpackage : mul_pkg

// File: rtl/mul_hilo_ctrl_if.sv
// Bus between the MULT sequencer and the shared Booth multiplier.
// Handshake: operands are held stable while mul_run is high; the multiplier
// raises mul_valid with mul_result once per run, and mul_run low resets it.
interface mul_hilo_ctrl_if;
  logic [31:0] mul_multiplicand;
  logic [31:0] mul_multiplier;
  logic        mul_run;
  logic        mul_valid;
  logic [63:0] mul_result;

  modport master (
    output mul_multiplicand, mul_multiplier, mul_run,
    input  mul_valid, mul_result
  );

  modport slave (
    input  mul_multiplicand, mul_multiplier, mul_run,
    output mul_valid, mul_result
  );
endinterface : mul_hilo_ctrl_if

// File: rtl/mul_hilo_ctrl_hilo_regfile.sv
// HI/LO architectural register pair: full 64-bit product write, single-half
// MTHI/MTLO write, and a combinational MFHI/MFLO read mux.
module hilo_regfile
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prod_we,
  input  logic [63:0] prod,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  input  logic        rd_sel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  logic [31:0] hi_q, lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (prod_we) begin
      hi_q <= prod[63:32];
      lo_q <= prod[31:0];
    end else if (mt_we) begin
      if (mt_sel == HILO_SEL_HI) hi_q <= mt_data;
      else                       lo_q <= mt_data;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = (rd_sel == HILO_SEL_HI) ? hi_q : lo_q;

endmodule : hilo_regfile

// File: rtl/mul_hilo_ctrl.sv
// EX-stage MULT sequencer: arms the shared multiplier, commits the product
// to HI/LO, stalls dependent instructions, handles flush and watchdog abort.
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int RECOVER_CYC = RECOVER_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mf_req,
  input  logic        mf_sel,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  input  logic        flush,
  mul_hilo_ctrl_if.master mbus,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVER_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       mcand_q, mcand_d, mplier_q, mplier_d;
  logic              run_q;
  logic              tmo_q, tmo_d;
  logic              prod_we, mt_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      run_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      run_q    <= (state_d == ST_RUN);
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    tmo_d    = tmo_q;
    prod_we  = 1'b0;
    mt_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A MULT wins over a simultaneous MTHI/MTLO, which is dropped.
        if (mul_req && !flush) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          state_d  = ST_ARM;
        end else if (mt_we && !flush) begin
          mt_wr = 1'b1;
        end
      end
      ST_ARM: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        // Flush outranks a same-cycle product so a squashed MULT never commits.
        if (flush) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else if (mbus.mul_valid) begin
          prod_we = 1'b1;
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt_q == REC_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  hilo_regfile u_hilo (
    .clk     (clk),
    .rst_n   (rst_n),
    .prod_we (prod_we),
    .prod    (mbus.mul_result),
    .mt_we   (mt_wr),
    .mt_sel  (mt_sel),
    .mt_data (mt_data),
    .rd_sel  (mf_sel),
    .hi      (hi),
    .lo      (lo),
    .rd_data (mf_data)
  );

  assign mbus.mul_multiplicand = mcand_q;
  assign mbus.mul_multiplier   = mplier_q;
  assign mbus.mul_run          = run_q;

  assign busy        = (state_q != ST_IDLE);
  assign stall       = busy & (mul_req | mf_req | mt_we);
  assign timeout_err = tmo_q;
  assign dbg_state   = state_q;

endmodule : mul_hilo_ctrl

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a behavioural Booth multiplier and a
// HI/LO scoreboard.
module tb_mul_hilo_ctrl;
  import mul_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int BOUND   = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mul_req, mf_req, mf_sel, mt_we, mt_sel, flush;
  logic [31:0] op_a, op_b, mt_data;
  logic        stall, busy, timeout_err;
  logic [31:0] mf_data, hi, lo;
  logic [1:0]  dbg_state;

  mul_hilo_ctrl_if mbus ();

  mul_hilo_ctrl #(
    .TIMEOUT_CYC (TIMEOUT),
    .RECOVER_CYC (1),
    .CNT_W       (7)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mul_req     (mul_req),
    .op_a        (op_a),
    .op_b        (op_b),
    .mf_req      (mf_req),
    .mf_sel      (mf_sel),
    .mt_we       (mt_we),
    .mt_sel      (mt_sel),
    .mt_data     (mt_data),
    .flush       (flush),
    .mbus        (mbus),
    .stall       (stall),
    .mf_data     (mf_data),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural multiplier: product valid lat_cfg run cycles after mul_run rises
  int lat_cfg = 3;
  bit never_valid = 1'b0;
  int lat_cnt = 0;
  logic signed [63:0] m_pa, m_pb;

  initial begin
    mbus.mul_valid  = 1'b0;
    mbus.mul_result = '0;
  end

  always @(negedge clk) begin
    if (mbus.mul_run) begin
      lat_cnt = lat_cnt + 1;
      m_pa = $signed(mbus.mul_multiplicand);
      m_pb = $signed(mbus.mul_multiplier);
      mbus.mul_result = m_pa * m_pb;
      mbus.mul_valid  = (lat_cnt >= lat_cfg) && !never_valid;
    end else begin
      lat_cnt = 0;
      mbus.mul_valid = 1'b0;
    end
  end

  // scoreboard
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // drive one MULT for one cycle; push the expected HI/LO after it finishes
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit commits);
    logic signed [63:0] pa, pb, p;
    pa = $signed(a);
    pb = $signed(b);
    p  = pa * pb;
    if (commits) begin
      m_hi = p[63:32];
      m_lo = p[31:0];
    end
    exp_q.push_back({m_hi, m_lo});
    mul_req = 1'b1;
    op_a    = a;
    op_b    = b;
    tick();
    mul_req = 1'b0;
    op_a    = $urandom;
    op_b    = $urandom;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < BOUND) begin
      tick();
      n++;
    end
    chk({tag, "_idle_bound"}, busy, 1'b0);
  endtask

  task automatic sb_pop(input string tag);
    chk({tag, "_sb_depth"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) chk(tag, {hi, lo}, exp_q.pop_front());
  endtask

  initial begin
    int n;
    mul_req = 0; mf_req = 0; mf_sel = 0; mt_we = 0; mt_sel = 0; flush = 0;
    op_a = '0; op_b = '0; mt_data = '0;

    // reset state
    repeat (2) tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_run", mbus.mul_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_mcand", mbus.mul_multiplicand, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // 4 x -7, MFLO held during the multiply
    issue(32'd4, 32'hFFFF_FFF9, 1'b1);
    chk("t1_arm_run", mbus.mul_run, 0);
    chk("t1_busy", busy, 1);
    chk("t1_mcand", mbus.mul_multiplicand, 32'd4);
    chk("t1_mplier", mbus.mul_multiplier, 32'hFFFF_FFF9);
    tick();
    chk("t1_run_hi", mbus.mul_run, 1);
    mf_req = 1'b1; mf_sel = HILO_SEL_LO;
    #1 chk("t1_stall_mf", stall, 1);
    wait_idle("t1");
    chk("t1_stall_drop", stall, 0);
    chk("t1_mf_lo", mf_data, 32'hFFFF_FFE4);
    chk("t1_hi", hi, 32'hFFFF_FFFF);
    sb_pop("t1_hilo");
    mf_sel = HILO_SEL_HI;
    #1 chk("t1_mf_hi", mf_data, 32'hFFFF_FFFF);
    mf_req = 1'b0;

    // max positive squared, then a re-presented -1 x -1 stalled behind it
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    mul_req = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    n = 0;
    while (dbg_state != ST_IDLE && n < BOUND) begin
      chk("t2_stall", stall, 1);
      if (dbg_state == ST_RECOVER) chk("t2_rec_run", mbus.mul_run, 0);
      tick();
      n++;
    end
    chk("t2_idle_stall", stall, 0);
    chk("t2_gap_run", mbus.mul_run, 0);
    chk("t2_lo_first", lo, 32'h0000_0001);
    sb_pop("t2_hilo_first");
    m_hi = '0; m_lo = 32'd1;
    exp_q.push_back({m_hi, m_lo});
    tick();
    mul_req = 1'b0;
    chk("t2_second_arm", dbg_state, ST_ARM);
    chk("t2_second_run_low", mbus.mul_run, 0);
    wait_idle("t2b");
    sb_pop("t2_hilo_second");

    // MTHI / MTLO in IDLE
    mt_we = 1'b1; mt_sel = HILO_SEL_HI; mt_data = 32'hDEAD_BEEF;
    #1 chk("t3_stall", stall, 0);
    tick();
    mt_we = 1'b0;
    m_hi = 32'hDEAD_BEEF;
    chk("t3_hi", hi, m_hi);
    chk("t3_lo_kept", lo, m_lo);
    mt_we = 1'b1; mt_sel = HILO_SEL_LO; mt_data = 32'h1234_5678;
    tick();
    mt_we = 1'b0;
    m_lo = 32'h1234_5678;
    chk("t3_hilo_mtlo", {hi, lo}, {m_hi, m_lo});

    // MULT and MTLO together: the write must be dropped (MULT flushed so it cannot mask it)
    mul_req = 1'b1; op_a = 32'd3; op_b = 32'd5;
    mt_we = 1'b1; mt_sel = HILO_SEL_LO; mt_data = 32'hBAD0_BAD0;
    tick();
    mul_req = 1'b0; mt_we = 1'b0;
    chk("t4_mt_ignored", {hi, lo}, {m_hi, m_lo});
    chk("t4_accepted", busy, 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.push_back({m_hi, m_lo});
    wait_idle("t4");
    sb_pop("t4_hilo");

    // flush five cycles into RUN
    lat_cfg = 20;
    issue(32'd11, 32'd13, 1'b0);
    repeat (5) tick();
    chk("t5_running", mbus.mul_run, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_run_fall", mbus.mul_run, 0);
    chk("t5_recover_busy", busy, 1);
    tick();
    chk("t5_busy_drop", busy, 0);
    sb_pop("t5_hilo");

    // flush in the same cycle as mul_valid
    lat_cfg = 3;
    issue(32'd6, 32'd7, 1'b0);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("t6");
    sb_pop("t6_hilo");

    // flush in IDLE blocks acceptance
    mul_req = 1'b1; flush = 1'b1;
    tick();
    mul_req = 1'b0; flush = 1'b0;
    chk("t7_not_accepted", busy, 0);

    // random signed multiplies
    for (int i = 0; i < 4; i++) begin
      lat_cfg = $urandom_range(1, 6);
      issue($urandom, $urandom, 1'b1);
      wait_idle("t8");
      sb_pop("t8_hilo");
    end

    // watchdog
    never_valid = 1'b1;
    issue(32'd2, 32'd3, 1'b0);
    n = 0;
    tick();
    while (dbg_state == ST_RUN && n < BOUND) begin
      n++;
      tick();
    end
    chk("t9_run_cycles", n, TIMEOUT);
    chk("t9_tmo_set", timeout_err, 1);
    wait_idle("t9");
    sb_pop("t9_hilo");
    never_valid = 1'b0;
    lat_cfg = 3;
    issue(32'd5, 32'd5, 1'b1);
    wait_idle("t9b");
    sb_pop("t9b_hilo");
    chk("t9_tmo_sticky", timeout_err, 1);

    // asynchronous reset in the middle of RUN
    lat_cfg = 50;
    mul_req = 1'b1; op_a = 32'd9; op_b = 32'd9;
    tick();
    mul_req = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t10_run", mbus.mul_run, 0);
    chk("t10_hilo", {hi, lo}, 64'd0);
    chk("t10_busy", busy, 0);
    chk("t10_tmo", timeout_err, 0);
    chk("t10_ops", {mbus.mul_multiplicand, mbus.mul_multiplier}, 64'd0);
    chk("t10_state", dbg_state, ST_IDLE);
    m_hi = '0; m_lo = '0;
    tick();
    rst_n = 1'b1;
    tick();
    lat_cfg = 2;
    issue(32'hFFFF_FFFD, 32'd8, 1'b1);
    wait_idle("t11");
    sb_pop("t11_hilo");

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_mul_hilo_ctrl
